// File: rtl/uart_tx_bridge.sv
// 8N1 UART transmitter fed by one-cycle character strobes from the core.
// A small FIFO absorbs bursts; characters arriving while it is full are dropped and counted.
`timescale 1ns/1ps

// state | meaning
// IDLE  | line high, waiting for a buffered character
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next character at its end if one is waiting
module uart_tx_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [7:0]                  in_ch,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic [15:0]                 drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             drop;
  logic             pop;
  logic             has_data;
  logic             baud_done;

  // Fullness is judged on the registered count, so a same-edge pop never rescues a strobe.
  assign has_data  = (fifo_count != '0);
  assign in_ready  = (fifo_count != DEPTH_C);
  assign push      = in_valid && in_ready;
  assign drop      = in_valid && !in_ready;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign pop       = has_data && ((state == IDLE) || ((state == STOP) && baud_done));
  assign busy      = (state != IDLE) || has_data;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_ch;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      overflow <= drop;
      if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed bench for uart_tx_bridge with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
// Inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps

module tb_uart_tx_bridge;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_ch;
  logic        in_ready;
  logic        tx;
  logic        busy;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  logic rec [0:4095];
  int   rec_n = 0;
  bit   rec_en = 0;

  uart_tx_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ch(in_ch),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .overflow(overflow), .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Line recorder, one sample per cycle, used for decoding frames afterwards.
  always @(negedge clock) begin
    if (rec_en && rec_n < 4096) begin
      rec[rec_n] = tx;
      rec_n++;
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic decode(inout int p, output logic [7:0] b, output bit found);
    found = 0;
    b = 8'h00;
    while (!found && (p + 40 <= rec_n)) begin
      if (rec[p] == 1'b0) found = 1;
      else p++;
    end
    if (found) begin
      for (int k = 0; k < 8; k++) b[k] = rec[p + CPB*(k+1) + 2];
      p += 10*CPB;
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    bit         found;
    int         p;
    logic       t2 [0:119];
    logic [7:0] exp_b;

    reset = 1'b0;
    in_valid = 1'b0;
    in_ch = 8'h00;
    tick();
    tick();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_count", fifo_count, 4'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_drop", drop_count, 16'd0);
    reset = 1'b1;
    tick();

    // Single character 0x55
    in_valid = 1'b1; in_ch = 8'h55;
    tick();
    in_valid = 1'b0;
    chk("single_count", fifo_count, 4'd1);
    chk("single_tx_pre", tx, 1'b1);
    chk("single_busy", busy, 1'b1);
    tick();
    chk("single_count_pop", fifo_count, 4'd0);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("single_bit%0d", k), tx, frame_bit(8'h55, k));
        tick();
      end
    end
    chk("single_busy_end", busy, 1'b0);
    chk("single_tx_end", tx, 1'b1);

    // Back-to-back 0x41 0x42 0x43
    in_valid = 1'b1; in_ch = 8'h41;
    tick();
    in_ch = 8'h42;
    tick();
    for (int j = 0; j < 120; j++) begin
      in_valid = (j == 0);
      in_ch = 8'h43;
      exp_b = 8'h41 + 8'(j / 40);
      t2[j] = tx;
      chk($sformatf("b2b_cyc%0d", j), tx, frame_bit(exp_b, (j % 40) / CPB));
      tick();
    end
    in_valid = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) b[k] = t2[f*40 + CPB*(k+1) + 2];
      chk($sformatf("b2b_byte%0d", f), b, 8'h41 + 8'(f));
    end
    chk("b2b_busy_end", busy, 1'b0);
    chk("b2b_tx_end", tx, 1'b1);

    // Overflow: ten strobes into an eight-deep FIFO
    rec_en = 1;
    tick();
    p = rec_n;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_ch = 8'h30 + 8'(i);
      tick();
      chk($sformatf("ovf_count%0d", i), fifo_count, (i == 0) ? 4'd1 : ((i > 8) ? 4'd8 : 4'(i)));
      chk($sformatf("ovf_ready%0d", i), in_ready, (i >= 8) ? 1'b0 : 1'b1);
      chk($sformatf("ovf_pulse%0d", i), overflow, (i == 9) ? 1'b1 : 1'b0);
      chk($sformatf("ovf_drop%0d", i), drop_count, (i == 9) ? 16'd1 : 16'd0);
    end
    in_valid = 1'b0;
    tick();
    chk("ovf_pulse_end", overflow, 1'b0);
    chk("ovf_drop_end", drop_count, 16'd1);
    repeat (9*40 + 10) tick();
    rec_en = 0;
    for (int i = 0; i < 9; i++) begin
      decode(p, b, found);
      chk($sformatf("ovf_rx%0d", i), {found, b}, {1'b1, 8'h30 + 8'(i)});
    end
    decode(p, b, found);
    chk("ovf_no_extra", found, 1'b0);
    wait_idle("ovf_idle", 50);

    // Strobe while full on the same edge that ends STOP and pops
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_ch = 8'h60 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("pwf_full", fifo_count, 4'd8);
    chk("pwf_ready", in_ready, 1'b0);
    repeat (32) tick();
    chk("pwf_full_pre", fifo_count, 4'd8);
    in_valid = 1'b1; in_ch = 8'h7E;
    tick();
    in_valid = 1'b0;
    chk("pwf_count", fifo_count, 4'd7);
    chk("pwf_pulse", overflow, 1'b1);
    chk("pwf_drop", drop_count, 16'd2);
    tick();
    chk("pwf_pulse_end", overflow, 1'b0);
    wait_idle("pwf_idle", 400);

    // Saturation of drop_count
    for (int i = 0; i < 70000; i++) begin
      in_valid = 1'b1; in_ch = i[7:0];
      tick();
    end
    chk("sat_drop", drop_count, 16'hFFFF);
    repeat (50) tick();
    in_valid = 1'b0;
    chk("sat_hold", drop_count, 16'hFFFF);
    chk("sat_full", fifo_count, 4'd8);

    // Reset mid-frame
    reset = 1'b0;
    #1;
    chk("rst2_drop", drop_count, 16'd0);
    tick();
    reset = 1'b1;
    tick();
    in_valid = 1'b1; in_ch = 8'h0F;
    tick();
    in_ch = 8'h11;
    tick();
    in_valid = 1'b0;
    chk("mid_start", tx, 1'b0);
    chk("mid_count", fifo_count, 4'd1);
    repeat (17) tick();
    chk("mid_busy_pre", busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_tx", tx, 1'b1);
    chk("mid_count_rst", fifo_count, 4'd0);
    chk("mid_busy_rst", busy, 1'b0);
    chk("mid_ready_rst", in_ready, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("mid_discard_busy", busy, 1'b0);
    chk("mid_discard_tx", tx, 1'b1);
    rec_en = 1;
    tick();
    p = rec_n;
    in_valid = 1'b1; in_ch = 8'hA5;
    tick();
    in_valid = 1'b0;
    repeat (46) tick();
    rec_en = 0;
    decode(p, b, found);
    chk("mid_rx_a5", {found, b}, {1'b1, 8'hA5});
    chk("mid_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
